// File: rtl/piso_tx_sched_if.sv
// Handshake and serial-output bundle for piso_tx_sched.
// The requester side drives the master modport; the scheduler uses the slave modport.
interface piso_tx_sched_if #(
  parameter int WIDTH = 4
);
  logic             valid0;
  logic [WIDTH-1:0] data0;
  logic             valid1;
  logic [WIDTH-1:0] data1;
  logic             hold;
  logic             ack0;
  logic             ack1;
  logic             sdout;
  logic             sframe;
  logic             sowner;
  logic             busy;
  logic             done;

  modport master (
    output valid0, data0, valid1, data1, hold,
    input  ack0, ack1, sdout, sframe, sowner, busy, done
  );

  modport slave (
    input  valid0, data0, valid1, data1, hold,
    output ack0, ack1, sdout, sframe, sowner, busy, done
  );
endinterface

// File: rtl/piso_tx_sched.sv
// Two-requester round-robin scheduler feeding a MSB-first parallel-to-serial shifter.
// Every output is a flop; each word occupies WIDTH shift cycles plus one GAP cycle.
module piso_tx_sched #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  piso_tx_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             gnt;
  logic [WIDTH-1:0] gword;

  // On a tie the requester not served last wins; a lone request always wins.
  always_comb begin
    gnt   = (bus.valid0 & bus.valid1) ? ~last : bus.valid1;
    gword = gnt ? bus.data1 : bus.data0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      last       <= 1'b1;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.sdout  <= 1'b0;
      bus.sframe <= 1'b0;
      bus.sowner <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid0 | bus.valid1) begin
            state      <= SHIFT;
            sreg       <= gword;
            cnt        <= '0;
            last       <= gnt;
            bus.sowner <= gnt;
            bus.ack0   <= ~gnt;
            bus.ack1   <= gnt;
            bus.sdout  <= gword[WIDTH-1];
            bus.sframe <= 1'b1;
            bus.busy   <= 1'b1;
          end
        end
        SHIFT: begin
          if (!bus.hold) begin
            sreg <= sreg << 1;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(WIDTH-1)) begin
              state      <= GAP;
              bus.sframe <= 1'b0;
              bus.sdout  <= 1'b0;
              bus.done   <= 1'b1;
            end else begin
              bus.sdout <= sreg[WIDTH-2];
            end
          end
        end
        GAP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.sframe <= 1'b0;
          bus.sdout  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_piso_tx_sched.sv
// Directed bench for piso_tx_sched (WIDTH=4): vector table plus hand-written
// sequences for round-robin ties, async reset mid-frame and ignored requests.
module tb_piso_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  piso_tx_sched_if #(.WIDTH(4)) bus ();
  piso_tx_sched #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // exp = {ack0, ack1, sdout, sframe, sowner, busy, done}
  typedef struct {
    logic       v0;
    logic [3:0] d0;
    logic       v1;
    logic [3:0] d1;
    logic       hold;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic v0, logic [3:0] d0, logic v1, logic [3:0] d1,
                              logic hold, logic [6:0] exp);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.hold = hold; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {bus.ack0, bus.ack1, bus.sdout, bus.sframe, bus.sowner, bus.busy, bus.done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Drive one vector, let one edge sample it, then compare the registered outputs.
  task automatic apply(input vec_t v, input string nm);
    bus.valid0 = v.v0; bus.data0 = v.d0;
    bus.valid1 = v.v1; bus.data1 = v.d1;
    bus.hold   = v.hold;
    @(posedge clk); #1;
    chk(nm, {25'd0, outs()}, {25'd0, v.exp});
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    int         gcount, dcount, last_g, idx, fcount;
    logic [3:0] w, expw;

    bus.valid0 = 1'b0; bus.data0 = '0;
    bus.valid1 = 1'b0; bus.data1 = '0;
    bus.hold   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0",   bus.ack0,   0);
    chk("rst_ack1",   bus.ack1,   0);
    chk("rst_sdout",  bus.sdout,  0);
    chk("rst_sframe", bus.sframe, 0);
    chk("rst_sowner", bus.sowner, 0);
    chk("rst_busy",   bus.busy,   0);
    chk("rst_done",   bus.done,   0);
    @(negedge clk); rst = 1'b1;

    // Single word 1011 (hold in IDLE/GAP ignored), then 1100 with a 3-cycle hold on bit 2.
    tbl[0]  = mk(0, 4'h0, 0, 4'h0, 0, 7'b0000000);
    tbl[1]  = mk(1, 4'hB, 0, 4'h0, 1, 7'b1011010);
    tbl[2]  = mk(0, 4'hB, 0, 4'h0, 0, 7'b0001010);
    tbl[3]  = mk(0, 4'hB, 0, 4'h0, 0, 7'b0011010);
    tbl[4]  = mk(0, 4'hB, 0, 4'h0, 0, 7'b0011010);
    tbl[5]  = mk(0, 4'hB, 0, 4'h0, 0, 7'b0000011);
    tbl[6]  = mk(0, 4'hB, 0, 4'h0, 1, 7'b0000000);
    tbl[7]  = mk(1, 4'hC, 0, 4'h0, 0, 7'b1011010);
    tbl[8]  = mk(0, 4'hC, 0, 4'h0, 0, 7'b0011010);
    tbl[9]  = mk(0, 4'hC, 0, 4'h0, 1, 7'b0011010);
    tbl[10] = mk(0, 4'hC, 0, 4'h0, 1, 7'b0011010);
    tbl[11] = mk(0, 4'hC, 0, 4'h0, 1, 7'b0011010);
    tbl[12] = mk(0, 4'hC, 0, 4'h0, 0, 7'b0001010);
    tbl[13] = mk(0, 4'hC, 0, 4'h0, 0, 7'b0001010);
    tbl[14] = mk(0, 4'hC, 0, 4'h0, 0, 7'b0000011);
    tbl[15] = mk(0, 4'hC, 0, 4'h0, 0, 7'b0000000);

    fcount = 0;
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      if (i >= 7 && bus.sframe) fcount++;
    end
    chk("hold_frame_len", fcount, 7);

    // Continuous tie: grants alternate 0,1,0,... every WIDTH+2 cycles.
    pulse_reset();
    bus.valid0 = 1'b1; bus.data0 = 4'hA;
    bus.valid1 = 1'b1; bus.data1 = 4'h5;
    bus.hold   = 1'b0;
    gcount = 0; dcount = 0; last_g = 0; w = '0; expw = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      chk("rr_one_hot", bus.ack0 & bus.ack1, 0);
      if (bus.ack0 | bus.ack1) begin
        idx = int'(bus.ack1);
        chk("rr_order", idx, gcount % 2);
        chk("rr_owner", bus.sowner, idx);
        if (gcount > 0) chk("rr_period", c - last_g, 6);
        last_g = c;
        expw = (idx == 1) ? 4'h5 : 4'hA;
        gcount++;
      end
      if (bus.sframe) w = {w[2:0], bus.sdout};
      if (bus.done) begin
        chk("rr_word", w, expw);
        dcount++;
      end
    end
    chk("rr_grants", gcount, 5);
    chk("rr_dones",  dcount, 5);
    bus.valid0 = 1'b0; bus.valid1 = 1'b0;
    apply(mk(0, 4'h0, 0, 4'h0, 0, 7'b0000000), "rr_idle");

    // Async reset during the third bit; pending valid1 granted right after release.
    apply(mk(1, 4'hB, 0, 4'h0, 0, 7'b1011010), "ab_grant0");
    apply(mk(0, 4'hB, 1, 4'h6, 0, 7'b0001010), "ab_bit2");
    apply(mk(0, 4'hB, 1, 4'h6, 0, 7'b0011010), "ab_bit1");
    #3 rst = 1'b0;
    #1 chk("ab_async_outs", outs(), 0);
    @(posedge clk); #1;
    chk("ab_held_outs", outs(), 0);
    @(negedge clk); rst = 1'b1;
    apply(mk(0, 4'hB, 1, 4'h6, 0, 7'b0101110), "ab_grant1");

    // valid0 toggling in SHIFT/GAP is ignored; the following tie goes to requester 0.
    apply(mk(1, 4'hB, 1, 4'h6, 0, 7'b0011110), "ign_bit2");
    apply(mk(0, 4'hB, 1, 4'h6, 0, 7'b0011110), "ign_bit1");
    apply(mk(1, 4'hB, 1, 4'h6, 0, 7'b0001110), "ign_bit0");
    apply(mk(0, 4'hB, 1, 4'h6, 0, 7'b0000111), "ign_gap");
    apply(mk(1, 4'hB, 1, 4'h6, 0, 7'b0000100), "ign_idle");
    apply(mk(1, 4'hB, 1, 4'h6, 0, 7'b1011010), "tie_grant0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/piso_tx_sched.md
PISO_TX_SCHED -- requirements
Module: piso_tx_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning bits per serialized word (WIDTH >= 2).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low: rst=0 resets immediately; release is synchronous to clk.
REQ-004 The block SHALL have port valid0  input  1  requester 0 has a word pending.
REQ-005 The block SHALL have port data0  input  WIDTH  requester 0 word; held stable while valid0=1.
REQ-006 The block SHALL have port valid1  input  1  requester 1 has a word pending.
REQ-007 The block SHALL have port data1  input  WIDTH  requester 1 word; held stable while valid1=1.
REQ-008 The block SHALL have port hold  input  1  stall serialization while high.
REQ-009 The block SHALL have port ack0  output  1  one-cycle pulse: requester 0 word accepted.
REQ-010 The block SHALL have port ack1  output  1  one-cycle pulse: requester 1 word accepted.
REQ-011 The block SHALL have port sdout  output  1  serial data, MSB first.
REQ-012 The block SHALL have port sframe  output  1  high while sdout carries a valid bit.
REQ-013 The block SHALL have port sowner  output  1  index of requester whose word is on sdout; valid when sframe=1.
REQ-014 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse after last bit of a word.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT and GAP, all outputs registered.
REQ-017 In IDLE, when valid0 or valid1 is sampled high at edge T, the block SHALL capture the granted word into a WIDTH-bit shift register, set sowner and enter SHIFT at edge T.
REQ-018 Arbitration SHALL be round-robin: with one valid high, that requester wins; with both high, the requester not granted last wins; the last-granted pointer SHALL point to requester 1 after reset, so requester 0 wins the first tie.
REQ-019 The granted ack SHALL be high for exactly the cycle after edge T and low otherwise; both acks SHALL never be high together.
REQ-020 In SHIFT, sframe SHALL be 1 and sdout SHALL equal the shift-register MSB; each edge with hold=0 SHALL shift left by one (zero fill) and increment a bit counter.
REQ-021 While hold=1 in SHIFT, the shift register, counter, sdout and sframe SHALL remain unchanged.
REQ-022 After the edge consuming bit 0 (counter = WIDTH-1, hold=0), the FSM SHALL enter GAP: sframe=0, sdout=0, done=1 for one cycle.
REQ-023 GAP SHALL last exactly one cycle and the FSM SHALL then return to IDLE, regardless of hold or valids.
REQ-024 valid0/valid1 SHALL be ignored in SHIFT and GAP; the minimum word-to-word period SHALL be WIDTH+2 cycles.
REQ-025 hold SHALL have no effect in IDLE or GAP.
REQ-026 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL clear on entry to SHIFT.

Reset
REQ-027 While rst=0, the state SHALL be IDLE; sdout, sframe, sowner, busy, done, ack0 and ack1 SHALL be 0; the shift register and counter SHALL be 0; the last-granted pointer SHALL be 1.
REQ-028 Asserting rst mid-frame SHALL abort the word immediately with no done pulse; the word is lost and the requester is not re-acked.
REQ-029 On the first edge after rst release, the block SHALL be able to grant.

Verification (WIDTH=4)
REQ-030 The bench SHALL check: valid0=1, data0=4'b1011 sampled at edge T -> ack0=1 in cycle T+1 only; sdout=1,0,1,1 with sframe=1 in cycles T+1..T+4; done=1 in T+5; busy=0 in T+6.
REQ-031 The bench SHALL check: valid0=valid1=1 continuously, data0=4'hA, data1=4'h5 -> words are granted alternately 0,1,0,1; grants are 6 cycles apart; sowner matches.
REQ-032 The bench SHALL check: hold=1 for 3 cycles during the second bit of 4'b1100 -> sdout stays 1 for 4 cycles; the frame lasts 7 sframe cycles; the bit sequence is unchanged.
REQ-033 The bench SHALL check: rst=0 asynchronously during the third bit -> all outputs are 0 before the next edge; no done; after release, pending valid1 is granted first.
REQ-034 The bench SHALL check: only valid1 is high after reset -> requester 1 is granted; a following tie -> requester 0 is granted.
REQ-035 The bench SHALL check: valid0 toggled during SHIFT and GAP -> no ack and no state change until IDLE.
